i2c_target_regs: RTL

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs_pkg.sv | 21 ++
 rtl/i2c_target_regs_if.sv | 11 +
 rtl/i2c_line_sync.sv | 45 ++++
 rtl/i2c_target_regs.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C target register block: FSM encoding,
// register-file geometry and the position of the R/W bit in the address byte.
package i2c_target_regs_pkg;

    localparam int NUM_REGS = 8;
    localparam int PTR_W    = 3;
    localparam int RW_BIT   = 0;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RD_MACK
    } state_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// I2C pin bundle. The target never drives SCL; SDA is open-drain through
// sdaO (always 0) and the tristate control sdaT (1 = released).
interface i2c_target_regs_if;
    logic sclI;
    logic sdaI;
    logic sdaO;
    logic sdaT;

    modport master (output sclI, output sdaI, input sdaO, input sdaT);
    modport slave  (input sclI, input sdaI, output sdaO, output sdaT);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and derives SCL edges plus
// START/STOP conditions from the synchronized levels.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetN,
    input  logic sclI,
    input  logic sdaI,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl;

    // Everything resets high (idle bus) so releasing reset cannot look like START/STOP.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= SYNC_STAGES'({scl_sync, sclI});
            sda_sync <= SYNC_STAGES'({sda_sync, sdaI});
            scl_hist <= scl;
            sda_hist <= sda;
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_hist;
    assign scl_fall  = ~scl & scl_hist;
    assign start_det = scl & scl_hist & sda_hist & ~sda;
    assign stop_det  = scl & scl_hist & ~sda_hist & sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing eight 8-bit registers through a pointer byte, with a
// fabric-side load port and a per-byte write strobe.
module i2c_target_regs
    import i2c_target_regs_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h58,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                resetN,
    i2c_target_regs_if.slave    bus,
    output logic                wrStrobe,
    output logic [PTR_W-1:0]    wrAddr,
    output logic [7:0]          wrData,
    input  logic                ldEn,
    input  logic [PTR_W-1:0]    ldAddr,
    input  logic [7:0]          ldData,
    output logic [8*NUM_REGS-1:0] regFlat,
    output logic                busy,
    output state_t              state_dbg
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .resetN    (resetN),
        .sclI      (bus.sclI),
        .sdaI      (bus.sdaI),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t           state;
    logic [3:0]       bit_cnt;
    logic [7:0]       shifter;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [7:0]       rx_byte;
    logic             sda_t_q;
    logic [7:0]       regs [NUM_REGS];

    assign rx_byte  = {shifter[6:0], sda};
    assign ptr_next = ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shifter  <= '0;
            ptr      <= '0;
            sda_t_q  <= 1'b1;
            wrStrobe <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wrStrobe <= 1'b0;
            // Bus writes below are assigned later, so they override a same-clk load.
            if (ldEn) regs[ldAddr] <= ldData;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_t_q <= 1'b1;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                sda_t_q <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shifter <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shifter[7:1] == DEV_ADDR) begin
                                sda_t_q <= 1'b0;
                                busy    <= 1'b1;
                                state   <= ADDR_ACK;
                            end else begin
                                state   <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            // Released SDA reads as 1, so the tristate control equals the data bit.
                            if (shifter[RW_BIT]) begin
                                shifter <= regs[ptr];
                                sda_t_q <= regs[ptr][7];
                                state   <= RDATA;
                            end else begin
                                sda_t_q <= 1'b1;
                                state   <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shifter <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            ptr     <= shifter[PTR_W-1:0];
                            sda_t_q <= 1'b0;
                            state   <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_t_q <= 1'b1;
                            state   <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shifter <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                regs[ptr] <= rx_byte;
                                wrStrobe  <= 1'b1;
                                wrAddr    <= ptr;
                                wrData    <= rx_byte;
                                ptr       <= ptr_next;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            sda_t_q <= 1'b0;
                            state   <= WDATA_ACK;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                sda_t_q <= 1'b1;
                                state   <= RD_MACK;
                            end else begin
                                shifter <= {shifter[6:0], 1'b0};
                                sda_t_q <= shifter[6];
                            end
                        end
                    end
                    RD_MACK: begin
                        // A fall here can only follow a master ACK; NACK leaves on the rise.
                        if (scl_rise && sda) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (scl_fall) begin
                            ptr     <= ptr_next;
                            shifter <= regs[ptr_next];
                            sda_t_q <= regs[ptr_next][7];
                            state   <= RDATA;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regFlat[8*i +: 8] = regs[i];
    end

    assign bus.sdaO  = 1'b0;
    assign bus.sdaT  = sda_t_q;
    assign state_dbg = state;

endmodule
